// File: rtl/finder_pattern_scanner_if.sv
// Scanner bus: start request, frame-buffer read port, pattern masks and status.
interface finder_pattern_scanner_if;
   logic         start_scan;
   logic         pixel_reading;
   logic [19:0]  address_reading;
   logic [479:0] horz_patterns;
   logic [479:0] vert_patterns;
   logic         start_cross;
   logic         busy;

   modport master (
      output start_scan, pixel_reading,
      input  address_reading, horz_patterns, vert_patterns, start_cross, busy
   );
   modport slave (
      input  start_scan, pixel_reading,
      output address_reading, horz_patterns, vert_patterns, start_cross, busy
   );
endinterface

// File: rtl/finder_pattern_scanner.sv
// Row-major then column-major scan of a binarised frame, flagging lines that carry a
// 1:1:3:1:1 finder signature; pulses start_cross once both masks are final.
module finder_pattern_scanner #(
   parameter int WIDTH        = 480,
   parameter int HEIGHT       = 480,
   parameter int READ_LATENCY = 2
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   finder_pattern_scanner_if.slave   bus
);
   localparam int DW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [2:0] {IDLE, ROW_SCAN, ROW_DRAIN, COL_SCAN, COL_DRAIN, DONE} state_t;
   typedef struct packed {
      logic       valid;
      logic       col;
      logic       eol;
      logic [8:0] line;
   } tag_t;

   // Window test; index 2 is the centre run, the other four share the same bounds.
   function automatic logic window_ok(input logic [4:0][8:0] h);
      logic [9:0]  t;
      logic [13:0] t14;
      logic [13:0] r14;
      logic        ok;
      t   = 10'(h[0]) + 10'(h[1]) + 10'(h[2]) + 10'(h[3]) + 10'(h[4]);
      t14 = 14'(t);
      ok  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         r14 = 14'(h[i]);
         if (i == 2)
            ok = ok & (r14 * 14'd7 >= t14 * 14'd2) & (r14 * 14'd7 <= t14 * 14'd4);
         else
            ok = ok & (r14 * 14'd14 >= t14) & (r14 * 14'd14 <= t14 * 14'd3);
      end
      return ok;
   endfunction

   state_t          state_reg, state_next;
   logic [8:0]      x_reg, x_next, y_reg, y_next;
   logic [DW-1:0]   drain_reg, drain_next;
   logic [19:0]     address_reg, address_next;
   tag_t            issue_tag_reg, issue_tag_next, ret_tag;
   logic            issue_valid, issue_col, clear_masks;
   logic [8:0]      run_len_reg, run_len_next, len_mid;
   logic            run_color_reg, run_color_next, pix;
   logic [4:0][8:0] hist_reg, hist_next, hist_mid, hist_end;
   logic [2:0]      cnt_reg, cnt_next, cnt_mid, cnt_end;
   logic            hit;
   logic [479:0]    horz_reg, vert_reg;

   always_comb begin
      state_next  = state_reg;
      x_next      = x_reg;
      y_next      = y_reg;
      drain_next  = drain_reg;
      issue_valid = 1'b0;
      issue_col   = 1'b0;
      clear_masks = 1'b0;
      case (state_reg)
         IDLE: if (bus.start_scan) begin
            state_next  = ROW_SCAN;
            x_next      = 9'd0;
            y_next      = 9'd0;
            issue_valid = 1'b1;
            clear_masks = 1'b1;
         end
         ROW_SCAN: begin
            if (x_reg == 9'(WIDTH - 1)) begin
               if (y_reg == 9'(HEIGHT - 1)) begin
                  state_next = ROW_DRAIN;
                  drain_next = '0;
               end else begin
                  x_next      = 9'd0;
                  y_next      = y_reg + 9'd1;
                  issue_valid = 1'b1;
               end
            end else begin
               x_next      = x_reg + 9'd1;
               issue_valid = 1'b1;
            end
         end
         ROW_DRAIN: begin
            if (drain_reg == DW'(READ_LATENCY - 1)) begin
               state_next  = COL_SCAN;
               x_next      = 9'd0;
               y_next      = 9'd0;
               issue_valid = 1'b1;
               issue_col   = 1'b1;
            end else begin
               drain_next = drain_reg + 1'b1;
            end
         end
         COL_SCAN: begin
            if (y_reg == 9'(HEIGHT - 1)) begin
               if (x_reg == 9'(WIDTH - 1)) begin
                  state_next = COL_DRAIN;
                  drain_next = '0;
               end else begin
                  y_next      = 9'd0;
                  x_next      = x_reg + 9'd1;
                  issue_valid = 1'b1;
                  issue_col   = 1'b1;
               end
            end else begin
               y_next      = y_reg + 9'd1;
               issue_valid = 1'b1;
               issue_col   = 1'b1;
            end
         end
         COL_DRAIN: begin
            if (drain_reg == DW'(READ_LATENCY - 1))
               state_next = DONE;
            else
               drain_next = drain_reg + 1'b1;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      issue_tag_next.valid = issue_valid;
      issue_tag_next.col   = issue_col;
      issue_tag_next.line  = issue_col ? x_next : y_next;
      issue_tag_next.eol   = issue_col ? (y_next == 9'(HEIGHT - 1)) : (x_next == 9'(WIDTH - 1));
      address_next = issue_valid ? (20'(x_next) + 20'(y_next) * 20'(WIDTH)) : address_reg;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_reg     <= IDLE;
         x_reg         <= 9'd0;
         y_reg         <= 9'd0;
         drain_reg     <= '0;
         address_reg   <= 20'd0;
         issue_tag_reg <= '0;
      end else begin
         state_reg     <= state_next;
         x_reg         <= x_next;
         y_reg         <= y_next;
         drain_reg     <= drain_next;
         address_reg   <= address_next;
         issue_tag_reg <= issue_tag_next;
      end
   end

   // Tags travel beside the read so run logic sees line/eol of the returned pixel.
   for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
      tag_t stage_reg;
      tag_t stage_src;
      if (gi == 0) begin : g_head
         assign stage_src = issue_tag_reg;
      end else begin : g_body
         assign stage_src = g_pipe[gi-1].stage_reg;
      end
      always_ff @(posedge clk_in) begin
         if (rst_in) stage_reg <= '0;
         else        stage_reg <= stage_src;
      end
   end
   assign ret_tag = g_pipe[READ_LATENCY-1].stage_reg;
   assign pix     = bus.pixel_reading;

   // A colour change closes the old run; end of line then closes the final run too.
   always_comb begin
      run_len_next   = run_len_reg;
      run_color_next = run_color_reg;
      hist_next      = hist_reg;
      cnt_next       = cnt_reg;
      hist_mid       = hist_reg;
      cnt_mid        = cnt_reg;
      len_mid        = run_len_reg;
      hist_end       = hist_reg;
      cnt_end        = cnt_reg;
      hit            = 1'b0;
      if (ret_tag.valid) begin
         if (run_len_reg != 9'd0 && pix != run_color_reg) begin
            hist_mid = {hist_reg[3:0], run_len_reg};
            cnt_mid  = (cnt_reg == 3'd5) ? 3'd5 : cnt_reg + 3'd1;
            if (!run_color_reg && cnt_mid == 3'd5) hit = window_ok(hist_mid);
            len_mid  = 9'd1;
         end else begin
            len_mid  = (run_len_reg == 9'd511) ? 9'd511 : run_len_reg + 9'd1;
         end
         if (ret_tag.eol) begin
            hist_end = {hist_mid[3:0], len_mid};
            cnt_end  = (cnt_mid == 3'd5) ? 3'd5 : cnt_mid + 3'd1;
            if (!pix && cnt_end == 3'd5) hit = hit | window_ok(hist_end);
            run_len_next   = 9'd0;
            run_color_next = 1'b1;
            hist_next      = '0;
            cnt_next       = 3'd0;
         end else begin
            run_len_next   = len_mid;
            run_color_next = pix;
            hist_next      = hist_mid;
            cnt_next       = cnt_mid;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         run_len_reg   <= 9'd0;
         run_color_reg <= 1'b1;
         hist_reg      <= '0;
         cnt_reg       <= 3'd0;
         horz_reg      <= '0;
         vert_reg      <= '0;
      end else begin
         run_len_reg   <= run_len_next;
         run_color_reg <= run_color_next;
         hist_reg      <= hist_next;
         cnt_reg       <= cnt_next;
         if (clear_masks) begin
            horz_reg <= '0;
            vert_reg <= '0;
         end else if (hit) begin
            if (ret_tag.col) horz_reg[ret_tag.line] <= 1'b1;
            else             vert_reg[ret_tag.line] <= 1'b1;
         end
      end
   end

   assign bus.address_reading = address_reg;
   assign bus.horz_patterns   = horz_reg;
   assign bus.vert_patterns   = vert_reg;
   assign bus.start_cross     = (state_reg == DONE);
   assign bus.busy            = (state_reg != IDLE);
endmodule
